// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Registers decoded operands, shift selects, destination and control for the
// EX-stage shifter/ALU, inserts bubbles on flush and load-use hazards, and
// freezes on an external hold.
// Optional feature macro: ID_EX_FWD_EN
//   defined   - EX/MEM and MEM/WB results are forwarded onto ex_rd1/ex_rd2,
//               and only a load feeding the next instruction stalls.
//   undefined - ex_rd1/ex_rd2 are the raw registered operands; any RAW on an
//               instruction in EX or EX/MEM stalls until the capture-side
//               WB bypass can supply the value.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [4:0]        id_shamt,
    input  logic              id_sll,
    input  logic              id_srl,
    input  logic              id_sra,
    input  logic              id_v,
    input  logic [4:0]        id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              hold,
    input  logic              flush,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_dst,
    input  logic [31:0]       mem_result,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_dst,
    input  logic [31:0]       wb_result,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [31:0]       ex_rd1,
    output logic [31:0]       ex_rd2,
    output logic [4:0]        ex_shamt,
    output logic              ex_sll,
    output logic              ex_srl,
    output logic              ex_sra,
    output logic              ex_v,
    output logic [4:0]        ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl
);

    // Registered source numbers and raw operands.
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [31:0] ex_rd1_q;
    logic [31:0] ex_rd2_q;

    // Capture-side bypass covers the register file writing and reading the
    // same register in the same cycle.
    logic        wb_hit_rs;
    logic        wb_hit_rt;
    logic [31:0] cap_rd1;
    logic [31:0] cap_rd2;
    logic        load_use;

    assign wb_hit_rs = wb_regwrite && (wb_dst != 5'd0) && (wb_dst == id_rs);
    assign wb_hit_rt = wb_regwrite && (wb_dst != 5'd0) && (wb_dst == id_rt);
    assign cap_rd1   = wb_hit_rs ? wb_result : id_rd1;
    assign cap_rd2   = wb_hit_rt ? wb_result : id_rd2;

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be forwarded in time for the next instruction.
    assign load_use = ex_valid && ex_memread && (ex_dst != 5'd0) && id_valid &&
                      ((ex_dst == id_rs) || (ex_dst == id_rt));
`else
    // Without output forwarding every producer in EX or EX/MEM must drain to
    // WB before the consumer is captured through the WB bypass.
    logic ex_raw;
    logic mem_raw;
    assign ex_raw   = ex_valid && (ex_regwrite || ex_memread) && (ex_dst != 5'd0) &&
                      ((ex_dst == id_rs) || (ex_dst == id_rt));
    assign mem_raw  = mem_regwrite && (mem_dst != 5'd0) &&
                      ((mem_dst == id_rs) || (mem_dst == id_rt));
    assign load_use = id_valid && (ex_raw || mem_raw);
`endif

    assign stall_out = hold || load_use;

    // Pipeline register: reset clears, hold freezes, flush/hazard loads a
    // bubble, otherwise the ID instruction is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd1_q    <= 32'd0;
            ex_rd2_q    <= 32'd0;
            ex_shamt    <= 5'd0;
            ex_sll      <= 1'b0;
            ex_srl      <= 1'b0;
            ex_sra      <= 1'b0;
            ex_v        <= 1'b0;
            ex_dst      <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_ctrl     <= '0;
        end else if (!hold) begin
            if (flush || load_use) begin
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_rs       <= 5'd0;
                ex_rt       <= 5'd0;
                ex_rd1_q    <= 32'd0;
                ex_rd2_q    <= 32'd0;
                ex_shamt    <= 5'd0;
                ex_sll      <= 1'b0;
                ex_srl      <= 1'b0;
                ex_sra      <= 1'b0;
                ex_v        <= 1'b0;
                ex_dst      <= 5'd0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_ctrl     <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_rd1_q    <= cap_rd1;
                ex_rd2_q    <= cap_rd2;
                ex_shamt    <= id_shamt;
                ex_sll      <= id_sll;
                ex_srl      <= id_srl;
                ex_sra      <= id_sra;
                ex_v        <= id_v;
                ex_dst      <= id_dst;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_ctrl     <= id_ctrl;
            end
        end
    end

`ifdef ID_EX_FWD_EN
    // Output forwarding per operand; EX/MEM is younger so it wins over MEM/WB.
    always_comb begin
        ex_rd1 = ex_rd1_q;
        ex_rd2 = ex_rd2_q;
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_rs)) begin
            ex_rd1 = mem_result;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_rs)) begin
            ex_rd1 = wb_result;
        end
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_rt)) begin
            ex_rd2 = mem_result;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_rt)) begin
            ex_rd2 = wb_result;
        end
    end
`else
    assign ex_rd1 = ex_rd1_q;
    assign ex_rd2 = ex_rd2_q;

    // Source numbers and the EX/MEM result only matter when forwarding.
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs, ex_rt, mem_result};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Expectations follow the build: ID_EX_FWD_EN selects output forwarding
// results, otherwise the widened-stall behaviour is expected.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [4:0]  id_shamt;
    logic        id_sll;
    logic        id_srl;
    logic        id_sra;
    logic        id_v;
    logic [4:0]  id_dst;
    logic        id_regwrite;
    logic        id_memread;
    logic [7:0]  id_ctrl;
    logic        hold;
    logic        flush;
    logic        mem_regwrite;
    logic [4:0]  mem_dst;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;
    logic        stall_out;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [4:0]  ex_shamt;
    logic        ex_sll;
    logic        ex_srl;
    logic        ex_sra;
    logic        ex_v;
    logic [4:0]  ex_dst;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [7:0]  ex_ctrl;

    int compareCount  = 0;
    int mismatchCount = 0;

    id_ex_stage #(.CTRL_W(8), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_shamt(id_shamt),
        .id_sll(id_sll), .id_srl(id_srl), .id_sra(id_sra), .id_v(id_v),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_shamt(ex_shamt),
        .ex_sll(ex_sll), .ex_srl(ex_srl), .ex_sra(ex_sra), .ex_v(ex_v),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_ctrl(ex_ctrl)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one ID instruction; shiftSel is {sll, srl, sra, v}.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [4:0] shamt, input logic [3:0] shiftSel,
                                 input logic [4:0] dst, input logic regwrite,
                                 input logic memread, input logic [7:0] ctrl);
        id_valid    = valid;
        id_pc       = pc;
        id_rs       = rs;
        id_rt       = rt;
        id_rd1      = rd1;
        id_rd2      = rd2;
        id_shamt    = shamt;
        id_sll      = shiftSel[3];
        id_srl      = shiftSel[2];
        id_sra      = shiftSel[1];
        id_v        = shiftSel[0];
        id_dst      = dst;
        id_regwrite = regwrite;
        id_memread  = memread;
        id_ctrl     = ctrl;
        #1;
    endtask

    task automatic stepClock;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        mem_regwrite = 1'b0; mem_dst = 5'd0; mem_result = 32'd0;
        wb_regwrite = 1'b0; wb_dst = 5'd0; wb_result = 32'd0;
        applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 32'hAAAA, 32'hBBBB, 5'd0, 4'b0000,
                      5'd3, 1'b1, 1'b0, 8'h11);

        // Reset held two cycles with a valid instruction waiting
        stepClock;
        stepClock;
        checkOutput("rst_valid", ex_valid, 0);
        checkOutput("rst_pc", ex_pc, 0);
        checkOutput("rst_rd1", ex_rd1, 0);
        checkOutput("rst_dst", ex_dst, 0);
        checkOutput("rst_regwrite", ex_regwrite, 0);
        checkOutput("rst_ctrl", ex_ctrl, 0);
        checkOutput("rst_stall", stall_out, 0);

        // First edge after reset captures the waiting instruction
        rst_n = 1'b1;
        stepClock;
        checkOutput("cap_valid", ex_valid, 1);
        checkOutput("cap_pc", ex_pc, 32'h100);
        checkOutput("cap_rd1", ex_rd1, 32'hAAAA);
        checkOutput("cap_dst", ex_dst, 3);
        checkOutput("cap_ctrl", ex_ctrl, 8'h11);

        // sll pass-through
        applyStimulus(1'b1, 32'h104, 5'd0, 5'd9, 32'd0, 32'h0000_00F0, 5'd4, 4'b1000,
                      5'd10, 1'b1, 1'b0, 8'hA5);
        checkOutput("sll_nostall", stall_out, 0);
        stepClock;
        checkOutput("sll_valid", ex_valid, 1);
        checkOutput("sll_rd2", ex_rd2, 32'h0000_00F0);
        checkOutput("sll_shamt", ex_shamt, 4);
        checkOutput("sll_sel", {ex_sll, ex_srl, ex_sra, ex_v}, 4'b1000);
        checkOutput("sll_ctrl", ex_ctrl, 8'hA5);
        checkOutput("sll_pc", ex_pc, 32'h104);

        // Forward priority with registered rs=5, rt=6
        applyStimulus(1'b1, 32'h108, 5'd5, 5'd6, 32'h55, 32'h66, 5'd0, 4'b0000,
                      5'd7, 1'b1, 1'b0, 8'h00);
        stepClock;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        mem_regwrite = 1'b1; mem_dst = 5'd5; mem_result = 32'h11;
        wb_regwrite = 1'b1; wb_dst = 5'd5; wb_result = 32'h22;
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_mem_wins", ex_rd1, 32'h11);
`else
        checkOutput("fwd_raw_rd1", ex_rd1, 32'h55);
`endif
        checkOutput("fwd_rd2_nomatch", ex_rd2, 32'h66);
        mem_regwrite = 1'b0;
        #1;
`ifdef ID_EX_FWD_EN
        checkOutput("fwd_wb", ex_rd1, 32'h22);
`else
        checkOutput("fwd_raw_rd1_wb", ex_rd1, 32'h55);
`endif
        mem_regwrite = 1'b0; mem_dst = 5'd0; wb_regwrite = 1'b0; wb_dst = 5'd0;

        // Register 0 is never forwarded
        applyStimulus(1'b1, 32'h10C, 5'd0, 5'd0, 32'h77, 32'h88, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        stepClock;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        mem_regwrite = 1'b1; mem_dst = 5'd0; mem_result = 32'h11;
        wb_regwrite = 1'b1; wb_dst = 5'd0; wb_result = 32'h22;
        #1;
        checkOutput("r0_rd1", ex_rd1, 32'h77);
        checkOutput("r0_rd2", ex_rd2, 32'h88);
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;

        // Load-use: lw $8 in EX, srlv reading $8 in ID
        applyStimulus(1'b1, 32'h110, 5'd1, 5'd8, 32'h1000, 32'd0, 5'd0, 4'b0000,
                      5'd8, 1'b1, 1'b1, 8'h00);
        stepClock;
        applyStimulus(1'b1, 32'h114, 5'd8, 5'd9, 32'hDEAD, 32'h8000_0000, 5'd0, 4'b0101,
                      5'd11, 1'b1, 1'b0, 8'h5A);
        checkOutput("lu_stall", stall_out, 1);
        stepClock;
        mem_regwrite = 1'b1; mem_dst = 5'd8; mem_result = 32'h4;
        #1;
        checkOutput("lu_bubble_valid", ex_valid, 0);
        checkOutput("lu_bubble_regwrite", ex_regwrite, 0);
        checkOutput("lu_bubble_ctrl", ex_ctrl, 0);
        checkOutput("lu_bubble_sel", {ex_sll, ex_srl, ex_sra, ex_v}, 0);
`ifdef ID_EX_FWD_EN
        checkOutput("lu_stall_release", stall_out, 0);
        stepClock;
        mem_regwrite = 1'b0; wb_regwrite = 1'b1; wb_dst = 5'd8; wb_result = 32'h4;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        checkOutput("lu_fwd_rd1", ex_rd1, 32'h4);
`else
        checkOutput("lu_stall_mem", stall_out, 1);
        stepClock;
        mem_regwrite = 1'b0; wb_regwrite = 1'b1; wb_dst = 5'd8; wb_result = 32'h4;
        #1;
        checkOutput("lu_bubble2_valid", ex_valid, 0);
        checkOutput("lu_stall_release", stall_out, 0);
        stepClock;
        wb_regwrite = 1'b0; wb_dst = 5'd0; wb_result = 32'h999;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        checkOutput("lu_bypass_rd1", ex_rd1, 32'h4);
`endif
        checkOutput("lu_enter_valid", ex_valid, 1);
        checkOutput("lu_enter_pc", ex_pc, 32'h114);
        checkOutput("lu_enter_sel", {ex_sll, ex_srl, ex_sra, ex_v}, 4'b0101);
        checkOutput("lu_enter_rd2", ex_rd2, 32'h8000_0000);
        wb_regwrite = 1'b0; wb_dst = 5'd0;

        // Hold beats flush; the flush is re-presented after hold drops
        applyStimulus(1'b1, 32'h118, 5'd0, 5'd0, 32'd1, 32'd2, 5'd0, 4'b0000,
                      5'd12, 1'b1, 1'b0, 8'h3C);
        hold = 1'b1; flush = 1'b1;
        #1;
        checkOutput("hold_stall", stall_out, 1);
        stepClock;
        checkOutput("hold_pc", ex_pc, 32'h114);
        checkOutput("hold_valid", ex_valid, 1);
        checkOutput("hold_dst", ex_dst, 11);
        hold = 1'b0;
        #1;
        checkOutput("flush_nostall", stall_out, 0);
        stepClock;
        checkOutput("flush_valid", ex_valid, 0);
        checkOutput("flush_pc", ex_pc, 0);
        checkOutput("flush_regwrite", ex_regwrite, 0);
        checkOutput("flush_ctrl", ex_ctrl, 0);
        flush = 1'b0;

        // Capture-side WB bypass persists after WB moves on
        applyStimulus(1'b1, 32'h11C, 5'd0, 5'd3, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd13, 1'b1, 1'b0, 8'h00);
        wb_regwrite = 1'b1; wb_dst = 5'd3; wb_result = 32'hABCD;
        #1;
        checkOutput("byp_nostall", stall_out, 0);
        stepClock;
        wb_regwrite = 1'b0; wb_dst = 5'd0; wb_result = 32'h1234;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 4'b0000,
                      5'd0, 1'b0, 1'b0, 8'h00);
        checkOutput("byp_rd2", ex_rd2, 32'hABCD);
        checkOutput("byp_valid", ex_valid, 1);
        stepClock;
        checkOutput("idle_valid", ex_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; sits directly upstream of the EX-stage shifter/ALU.
- Registers decoded operands and control: rd1, rd2, shamt, shift selects (sll/srl/sra, variable flag), destination, write/load flags.
- Applies operand forwarding from EX/MEM and MEM/WB at its outputs.
- Detects load-use hazards and inserts bubbles.
- Honours an external hold and a branch flush.

Parameters:
- CTRL_W, 8, width of pass-through control bundle (ALU op, mem write, etc.); zeroed in bubbles.
- PC_W, 32, width of the carried PC.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  PC_W  PC of ID instruction
- id_rs, id_rt  in  5  source register numbers
- id_rd1, id_rd2  in  32  register-file read data
- id_shamt  in  5  instruction shift amount
- id_sll, id_srl, id_sra, id_v  in  1  shift selects and variable-shift flag
- id_dst  in  5  destination register
- id_regwrite, id_memread  in  1  writes GPR / is a load
- id_ctrl  in  CTRL_W  pass-through control
- hold  in  1  downstream stall (e.g. mult/div busy); freeze stage
- flush  in  1  branch/exception squash of ID instruction
- mem_regwrite  in  1  EX/MEM writes GPR
- mem_dst  in  5  EX/MEM destination
- mem_result  in  32  EX/MEM result
- wb_regwrite  in  1  MEM/WB writes GPR
- wb_dst  in  5  MEM/WB destination
- wb_result  in  32  MEM/WB result
- stall_out  out  1  freeze PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc  out  PC_W  registered PC
- ex_rd1, ex_rd2  out  32  forwarded operands to shifter/ALU
- ex_shamt  out  5  registered shamt
- ex_sll, ex_srl, ex_sra, ex_v  out  1  registered shift selects
- ex_dst  out  5  registered destination
- ex_regwrite, ex_memread  out  1  registered flags
- ex_ctrl  out  CTRL_W  registered control

Behaviour:
- Reset (rst_n=0 at edge): all registered fields 0. ex_valid=0, stall_out=0.
- Bubble: valid, regwrite, memread, shift selects and ctrl are 0. Data fields are don't-care but driven 0.
- load_use = ex_valid & ex_memread & ex_dst!=0 & id_valid & (ex_dst==id_rs | ex_dst==id_rt). The check is purely combinational.
- stall_out = hold | load_use.
- Edge update priority, highest first:
  - rst_n=0: clear all registers.
  - hold: keep all registers. This holds even with flush, and the flush request must be re-presented.
  - flush: load a bubble.
  - load_use: load a bubble. ID holds via stall_out, so the instruction re-enters one cycle later.
  - Otherwise: capture the ID fields, with ex_valid=id_valid.
- Capture-side bypass, applied to each operand independently:
  - Capture wb_result instead of id_rd1 when wb_regwrite & wb_dst!=0 & wb_dst==id_rs.
  - The same rule applies to id_rd2 with id_rt.
  - Covers the same-cycle write/read of the register file.
- Registered rs/rt numbers are kept internally for output forwarding.
- Output forwarding, combinational, per operand:
  - EX/MEM match (mem_regwrite, mem_dst!=0, equals registered src) selects mem_result.
  - Else MEM/WB match selects wb_result.
  - Else the registered value.
  - EX/MEM beats MEM/WB when both match.
  - Register 0 is never forwarded.
- Forwarding applies to ex_rd1 and ex_rd2 regardless of shift type. The shifter's variable-amount path reads ex_rd1[4:0], so it gets forwarded data.
- Latency: 1 cycle ID→EX. Throughput: 1 instruction per cycle when no stall.
- Under hold, ex_rd1 and ex_rd2 continue to re-forward each cycle as the mem/wb buses change.

Optional Feature:
- ID_EX_FWD_EN defined: capture-side bypass and output forwarding as above.
- ID_EX_FWD_EN undefined: no forwarding at the outputs. ex_rd1/ex_rd2 are the raw registered values; the capture-side WB bypass is kept.
- Undefined also widens load_use to any RAW: ex_valid & ex_regwrite & ex_dst!=0, plus mem_regwrite & mem_dst!=0 matching id_rs or id_rt.
- Correctness is preserved by stalling.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 → ex_valid=0, all outputs 0. First edge after rst_n=1 captures the ID instruction.
- sll pass-through: id_rd2=0x0000_00F0, id_shamt=4, id_sll=1, no matches → next cycle ex_rd2=0x0000_00F0, ex_shamt=4, ex_sll=1, ex_valid=1.
- EX/MEM forward beats WB: registered rs=5; mem_dst=5, mem_result=0x11; wb_dst=5, wb_result=0x22 → ex_rd1=0x11. With mem_regwrite=0 → 0x22. With rs=0 → registered value.
- Load-use: EX=lw to $8, ID=srlv reading $8 → stall_out=1 for exactly 1 cycle, one bubble (ex_valid=0). Then srlv enters with ex_rd1 forwarded from wb_result.
- Hold+flush: hold=1 and flush=1 together → EX unchanged and stall_out=1. Next cycle hold=0, flush=1 → bubble loaded.
- Capture bypass: wb_dst=3, wb_result=0xABCD, id_rt=3, id_rd2=0 → ex_rd2 registered 0xABCD, persisting after WB moves on.
